// File: rtl/mpu_pkg.sv
// mpu_pkg: shared FSM state encoding and default chunk width for the chunk serializer.
package mpu_pkg;

    localparam int DEFAULT_NUM_BITS = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_serializer.sv
// chunk_serializer: captures a NUM_BITS-wide chunk and streams its first len bytes, LSB first, to a host.
//   clk, rst          : clock and synchronous active-high reset
//   load              : capture chunk_in/len and start streaming (honoured only in IDLE)
//   chunk_in, len     : chunk to send, byte count (0 or too large means the whole chunk)
//   host_ready        : host accepts the offered byte this cycle
//   host_data, offset : offered byte and its index within the chunk
//   host_valid        : host_data is valid
//   busy, done        : stream in progress; one-cycle pulse after the last byte is accepted
module chunk_serializer
    import mpu_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [NUM_BITS-1:0] chunk_in,
    input  logic [7:0]          len,
    input  logic                host_ready,
    output logic [7:0]          host_data,
    output logic                host_valid,
    output logic [7:0]          offset,
    output logic                busy,
    output logic                done
);

    localparam int NB = NUM_BITS / 8;
    // Nine bits so a full 2048-bit chunk (256 bytes) is representable.
    localparam logic [8:0] NB9 = 9'(NB);

    state_t              state_q, state_d;
    logic [7:0]          idx_q, idx_d;
    logic [8:0]          len_q, len_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic [8:0]          len_eff;
    logic [7:0]          byte_sel;

    always_comb begin
        len_eff = (len == 8'd0 || {1'b0, len} > NB9) ? NB9 : {1'b0, len};
        byte_sel = 8'd0;
        for (int i = 0; i < NB; i++)
            if (idx_q == 8'(i)) byte_sel = data_q[8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (load) begin
                state_d = SEND;
                idx_d   = 8'd0;
                len_d   = len_eff;
                data_d  = chunk_in;
            end
            SEND: if (host_ready) begin
                if ({1'b0, idx_q} == len_q - 9'd1) state_d = DONE;
                else idx_d = idx_q + 8'd1;
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            len_q   <= 9'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        host_valid = state_q == SEND;
        host_data  = state_q == SEND ? byte_sel : 8'd0;
        offset     = state_q == SEND ? idx_q : 8'd0;
        busy       = state_q != IDLE;
        done       = state_q == DONE;
    end

endmodule

// File: tb/tb_chunk_serializer.sv
// tb_chunk_serializer: randomized scoreboard bench for chunk_serializer.
module tb_chunk_serializer;

    localparam int NBITS  = 512;
    localparam int NBYTES = NBITS / 8;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [NBITS-1:0] chunk_in = '0;
    logic [7:0]       len = 8'd0;
    logic             host_ready = 1'b0;
    logic [7:0]       host_data;
    logic             host_valid;
    logic [7:0]       offset;
    logic             busy;
    logic             done;

    exp_t exp_q[$];
    int   pending_done = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 0;

    chunk_serializer #(.NUM_BITS(NBITS)) dut (
        .clk(clk), .rst(rst), .load(load), .chunk_in(chunk_in), .len(len),
        .host_ready(host_ready), .host_data(host_data), .host_valid(host_valid),
        .offset(offset), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NBITS-1:0] rand_chunk();
        logic [NBITS-1:0] c;
        for (int i = 0; i < NBITS / 32; i++) c[32*i +: 32] = $urandom;
        return c;
    endfunction

    function automatic logic [NBITS-1:0] count_chunk();
        logic [NBITS-1:0] c;
        for (int i = 0; i < NBYTES; i++) c[8*i +: 8] = 8'(i);
        return c;
    endfunction

    // Reference model: the bytes a load must produce, in order, with their indices.
    task automatic expect_stream(input logic [NBITS-1:0] ch, input logic [7:0] ln);
        int eff;
        eff = (ln == 0 || ln > NBYTES) ? NBYTES : int'(ln);
        for (int i = 0; i < eff; i++) exp_q.push_back({ch[8*i +: 8], 8'(i)});
        pending_done++;
    endtask

    // mode 0: ready always high, 1: ready toggles 1,0,1,0..., 2: random ready
    task automatic run_stream(input logic [NBITS-1:0] ch, input logic [7:0] ln, input int mode, input bit stray);
        int eff, cyc;
        bit seen;
        eff = (ln == 0 || ln > NBYTES) ? NBYTES : int'(ln);
        expect_stream(ch, ln);
        @(posedge clk); #1;
        load = 1'b1; chunk_in = ch; len = ln;
        cyc = 1;
        seen = 0;
        @(posedge clk); #1;
        while (!seen && cyc < 3000) begin
            cyc++;
            host_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            load = stray && cyc == 5;
            chunk_in = stray && cyc == 5 ? ~ch : rand_chunk();
            len = 8'($urandom);
            @(negedge clk);
            if (done) seen = 1;
            @(posedge clk); #1;
        end
        load = 1'b0;
        if (!seen) chk("stream_timeout", 64'(cyc), 64'(eff + 2));
        else if (mode == 0) chk("done_cycle", 64'(cyc), 64'(eff + 2));
    endtask

    // Monitor: pops the scoreboard on every transfer and checks the status outputs.
    initial begin
        exp_t e;
        logic [7:0] pd, po;
        bit hold;
        hold = 0; pd = 0; po = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (hold && host_valid) begin
                    chk("hold_data", 64'(host_data), 64'(pd));
                    chk("hold_offset", 64'(offset), 64'(po));
                end
                hold = host_valid && !host_ready;
                pd = host_data;
                po = offset;
                chk("valid_iff_send", 64'(host_valid), 64'(busy && !done));
                if (host_valid && host_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_byte", 64'(offset), 64'hFFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("data", 64'(host_data), 64'(e.d));
                        chk("offset", 64'(offset), 64'(e.o));
                    end
                end
                if (done) begin
                    chk("done_expected", 64'(pending_done > 0), 64'd1);
                    chk("done_drained", 64'(exp_q.size()), 64'd0);
                    chk("done_busy", 64'(busy), 64'd1);
                    if (pending_done > 0) pending_done--;
                end
                if (!busy) chk("idle_outputs", 64'({host_valid, done, host_data, offset}), 64'd0);
            end
        end
    end

    initial begin
        logic [NBITS-1:0] ch;
        bit hit;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("reset_valid", 64'(host_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_data_off", 64'({host_data, offset}), 64'd0);

        run_stream(count_chunk(), 8'd0, 0, 0);
        run_stream(rand_chunk(), 8'd4, 1, 0);
        run_stream(rand_chunk(), 8'd200, 0, 0);
        run_stream(count_chunk(), 8'd1, 0, 0);
        run_stream(count_chunk(), 8'd20, 0, 1);
        run_stream(rand_chunk(), 8'd30, 2, 1);

        // Reset at byte 10 aborts the stream without a done pulse.
        ch = rand_chunk();
        expect_stream(ch, 8'd0);
        @(posedge clk); #1;
        load = 1'b1; chunk_in = ch; len = 8'd0; host_ready = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            hit = host_valid && offset == 8'd10;
        end
        chk("reach_byte10", 64'(hit), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        pending_done = 0;
        @(negedge clk);
        chk("rst_mid_valid", 64'(host_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_offset", 64'(offset), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        run_stream(count_chunk(), 8'd0, 0, 0);

        // Reset wins over a simultaneous load.
        @(posedge clk); #1;
        rst = 1'b1; load = 1'b1; chunk_in = rand_chunk(); len = 8'd5;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        @(negedge clk);
        chk("rst_load_busy", 64'(busy), 64'd0);
        chk("rst_load_valid", 64'(host_valid), 64'd0);

        for (int n = 0; n < 20; n++)
            run_stream(rand_chunk(), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge clk);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        chk("final_pending_done", 64'(pending_done), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
